// File: rtl/traffic_pkg.sv
// Shared lamp-bus definitions for the traffic cabinet: lamp encodings, approach
// directions, monitor fault codes and monitor states.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b100;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_INVALID  = 3'd1,
    FC_CONFLICT = 3'd2,
    FC_SEQUENCE = 3'd3,
    FC_SHORT    = 3'd4,
    FC_LONG     = 3'd5,
    FC_STALL    = 3'd6
  } fault_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } mon_state_e;

  function automatic logic lamp_valid(input logic [2:0] code);
    return (code == LAMP_RED) || (code == LAMP_YEL) || (code == LAMP_GRN);
  endfunction

  // Legal moves are hold, G->Y, Y->R and R->G; anything else is a sequencing error.
  function automatic logic lamp_step_ok(input logic [2:0] prev, input logic [2:0] cur);
    return (prev == cur) ||
           (prev == LAMP_GRN && cur == LAMP_YEL) ||
           (prev == LAMP_YEL && cur == LAMP_RED) ||
           (prev == LAMP_RED && cur == LAMP_GRN);
  endfunction

  // Lowest set index of a per-approach flag vector; DIR_N when none is set.
  function automatic dir_e first_set(input logic [3:0] v);
    first_set = DIR_N;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) first_set = dir_e'(2'(i));
    end
  endfunction

endpackage

// File: rtl/traffic_lamp_monitor_if.sv
// Lamp bus from the traffic controller plus the monitor's status/acknowledge
// signals towards the cabinet safety logic.
interface traffic_lamp_monitor_if;

  logic [2:0] north;
  logic [2:0] east;
  logic [2:0] south;
  logic [2:0] west;
  logic       clear;

  logic       armed;
  logic       fault;
  logic       flash_red;
  logic [2:0] fault_code;
  logic [1:0] fault_dir;
  logic [1:0] active_dir;
  logic       active_valid;

  modport master (
    output north, east, south, west, clear,
    input  armed, fault, flash_red, fault_code, fault_dir, active_dir, active_valid
  );

  modport slave (
    input  north, east, south, west, clear,
    output armed, fault, flash_red, fault_code, fault_dir, active_dir, active_valid
  );

endinterface

// File: rtl/traffic_lamp_tracker.sv
// One approach of the lamp monitor: remembers the previous code, how long it has
// been held and whether the unknown-length first phase is still running.
module traffic_lamp_tracker
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 1,
  parameter int MAX_GREEN  = 16,
  parameter int MIN_YELLOW = 1,
  parameter int MAX_YELLOW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       capture,
  input  logic       track,
  input  logic [2:0] code,
  output logic       invalid,
  output logic       seq_err,
  output logic       short_err,
  output logic       long_err,
  output logic       non_red
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_G_CNT = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MAX_G_CNT = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] MIN_Y_CNT = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAX_Y_CNT = CNT_W'(MAX_YELLOW);

  logic [2:0]       prev_code;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] dwell_next;
  logic             first_phase;
  logic             changed;

  assign changed    = code != prev_code;
  assign dwell_next = changed ? CNT_ONE : ((dwell == CNT_MAX) ? dwell : dwell + CNT_ONE);

  assign invalid = !lamp_valid(code);
  assign seq_err = !lamp_step_ok(prev_code, code);
  assign non_red = code != LAMP_RED;

  // dwell is the held length of prev_code, so the minimum is judged on the
  // phase that is ending; it is meaningless until the first change completes.
  assign short_err = !first_phase &&
                     ((prev_code == LAMP_GRN && code == LAMP_YEL && dwell < MIN_G_CNT) ||
                      (prev_code == LAMP_YEL && code == LAMP_RED && dwell < MIN_Y_CNT));

  assign long_err = (code == LAMP_GRN && dwell_next > MAX_G_CNT) ||
                    (code == LAMP_YEL && dwell_next > MAX_Y_CNT);

  // NOTE: this cabinet's rst_n is active-high despite its name, so the async
  // reset fires on posedge rst_n and the reset branch tests rst_n, not !rst_n.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      prev_code   <= LAMP_RED;
      dwell       <= '0;
      first_phase <= 1'b1;
    end else if (capture) begin
      prev_code   <= code;
      dwell       <= '0;
      first_phase <= 1'b1;
    end else if (track) begin
      prev_code <= code;
      dwell     <= dwell_next;
      if (changed) first_phase <= 1'b0;
    end
  end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Conflict monitor for the four-approach lamp bus: checks validity, right-of-way,
// sequencing and dwell limits, and latches the first fault as a flash-red request.
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int MIN_GREEN   = 1,
  parameter int MAX_GREEN   = 16,
  parameter int MIN_YELLOW  = 1,
  parameter int MAX_YELLOW  = 4,
  parameter int MAX_ALL_RED = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  traffic_lamp_monitor_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] MAX_AR_CNT = CNT_W'(MAX_ALL_RED);

  mon_state_e       state;
  logic             armed;
  logic             fault;
  fault_code_e      fault_code;
  dir_e             fault_dir;
  logic [CNT_W-1:0] all_red_cnt;
  logic [CNT_W-1:0] all_red_next;

  logic [3:0][2:0]  codes;
  logic [3:0]       invalid;
  logic [3:0]       seq_err;
  logic [3:0]       short_err;
  logic [3:0]       long_err;
  logic [3:0]       non_red;
  logic             capture;
  logic             track;
  logic             all_red;
  logic             conflict;
  logic             stall;
  fault_code_e      det_code;
  dir_e             det_dir;

  assign codes   = {bus.west, bus.south, bus.east, bus.north};
  assign capture = state == ST_IDLE;
  assign track   = state == ST_RUN;

  for (genvar i = 0; i < 4; i++) begin : g_trk
    traffic_lamp_tracker #(
      .CNT_W      (CNT_W),
      .MIN_GREEN  (MIN_GREEN),
      .MAX_GREEN  (MAX_GREEN),
      .MIN_YELLOW (MIN_YELLOW),
      .MAX_YELLOW (MAX_YELLOW)
    ) u_trk (
      .clk       (clk),
      .rst_n     (rst_n),
      .capture   (capture),
      .track     (track),
      .code      (codes[i]),
      .invalid   (invalid[i]),
      .seq_err   (seq_err[i]),
      .short_err (short_err[i]),
      .long_err  (long_err[i]),
      .non_red   (non_red[i])
    );
  end

  assign all_red      = non_red == 4'b0000;
  assign all_red_next = !all_red ? '0 :
                        ((all_red_cnt == CNT_MAX) ? all_red_cnt : all_red_cnt + CNT_ONE);
  assign stall        = all_red_next > MAX_AR_CNT;
  assign conflict     = $countones(non_red) > 1;

  // Lowest fault code wins; within a code the lowest approach index wins.
  // NOTE: det_code/det_dir get defaults before the if-chain so that every path
  // assigns them and no latch is inferred.
  always_comb begin
    det_code = FC_NONE;
    det_dir  = DIR_N;
    if (|invalid) begin
      det_code = FC_INVALID;
      det_dir  = first_set(invalid);
    end else if (conflict) begin
      det_code = FC_CONFLICT;
    end else if (|seq_err) begin
      det_code = FC_SEQUENCE;
      det_dir  = first_set(seq_err);
    end else if (|short_err) begin
      det_code = FC_SHORT;
      det_dir  = first_set(short_err);
    end else if (|long_err) begin
      det_code = FC_LONG;
      det_dir  = first_set(long_err);
    end else if (stall) begin
      det_code = FC_STALL;
    end
  end

  // In FAULT the trackers and all-red counter freeze; clear beats any new violation.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= ST_IDLE;
      armed       <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      fault_dir   <= DIR_N;
      all_red_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state       <= ST_RUN;
          armed       <= 1'b1;
          all_red_cnt <= '0;
        end
        ST_RUN: begin
          if (det_code != FC_NONE) begin
            state      <= ST_FAULT;
            armed      <= 1'b0;
            fault      <= 1'b1;
            fault_code <= det_code;
            fault_dir  <= det_dir;
          end else begin
            all_red_cnt <= all_red_next;
          end
        end
        ST_FAULT: begin
          if (bus.clear) begin
            state      <= ST_IDLE;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            fault_dir  <= DIR_N;
          end
        end
        default: begin
          state <= ST_IDLE;
          armed <= 1'b0;
        end
      endcase
    end
  end

  assign bus.armed        = armed;
  assign bus.fault        = fault;
  assign bus.flash_red    = fault;
  assign bus.fault_code   = fault_code;
  assign bus.fault_dir    = fault_dir;
  assign bus.active_dir   = first_set(non_red);
  assign bus.active_valid = $countones(non_red) == 1;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor: a default-parameter instance and a
// MIN_GREEN=3 instance share the lamp stimulus; expectations go through a queue.
module tb_traffic_lamp_monitor;
  import traffic_pkg::*;

  typedef logic [3:0][2:0] lamps_t;

  typedef struct {
    string      tag;
    bit         on_b;
    logic       armed;
    logic       fault;
    logic [2:0] code;
    logic [1:0] dir;
    logic       act_valid;
    logic [1:0] act_dir;
    bit         chk_act_dir;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n;
  lamps_t lamps;
  logic   clr;
  int     tests = 0;
  int     fails = 0;
  exp_t   sb[$];

  always #5 clk = ~clk;

  traffic_lamp_monitor_if bus_a ();
  traffic_lamp_monitor_if bus_b ();

  assign bus_a.north = lamps[0];
  assign bus_a.east  = lamps[1];
  assign bus_a.south = lamps[2];
  assign bus_a.west  = lamps[3];
  assign bus_a.clear = clr;
  assign bus_b.north = lamps[0];
  assign bus_b.east  = lamps[1];
  assign bus_b.south = lamps[2];
  assign bus_b.west  = lamps[3];
  assign bus_b.clear = clr;

  traffic_lamp_monitor dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  traffic_lamp_monitor #(.MIN_GREEN(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // All approaches red except d0 (and d1) showing the given codes; d = -1 means none.
  function automatic lamps_t lit2(input int d0, input logic [2:0] c0,
                                  input int d1, input logic [2:0] c1);
    lamps_t l;
    for (int i = 0; i < 4; i++) begin
      l[i] = (i == d0) ? c0 : ((i == d1) ? c1 : LAMP_RED);
    end
    return l;
  endfunction

  function automatic lamps_t lit(input int d, input logic [2:0] c);
    return lit2(d, c, -1, LAMP_RED);
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input bit on_b, input logic ea, input logic ef,
                            input logic [2:0] ec, input logic [1:0] ed);
    exp_t x;
    int   lit_n;
    lit_n     = 0;
    x.tag     = tag;
    x.on_b    = on_b;
    x.armed   = ea;
    x.fault   = ef;
    x.code    = ec;
    x.dir     = ed;
    x.act_dir = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (lamps[i] != LAMP_RED) begin
        lit_n++;
        x.act_dir = 2'(i);
      end
    end
    x.act_valid   = (lit_n == 1);
    x.chk_act_dir = (lit_n <= 1);
    sb.push_back(x);
  endtask

  task automatic check_front();
    exp_t       x;
    logic       armed_o, fault_o, flash_o, av_o;
    logic [2:0] code_o;
    logic [1:0] dir_o, ad_o;
    x = sb.pop_front();
    if (x.on_b) begin
      armed_o = bus_b.armed;   fault_o = bus_b.fault;     flash_o = bus_b.flash_red;
      code_o  = bus_b.fault_code; dir_o = bus_b.fault_dir;
      av_o    = bus_b.active_valid; ad_o = bus_b.active_dir;
    end else begin
      armed_o = bus_a.armed;   fault_o = bus_a.fault;     flash_o = bus_a.flash_red;
      code_o  = bus_a.fault_code; dir_o = bus_a.fault_dir;
      av_o    = bus_a.active_valid; ad_o = bus_a.active_dir;
    end
    check({x.tag, " armed"},        {3'b0, armed_o}, {3'b0, x.armed});
    check({x.tag, " fault"},        {3'b0, fault_o}, {3'b0, x.fault});
    check({x.tag, " flash_red"},    {3'b0, flash_o}, {3'b0, x.fault});
    check({x.tag, " fault_code"},   {1'b0, code_o},  {1'b0, x.code});
    check({x.tag, " fault_dir"},    {2'b0, dir_o},   {2'b0, x.dir});
    check({x.tag, " active_valid"}, {3'b0, av_o},    {3'b0, x.act_valid});
    if (x.chk_act_dir) check({x.tag, " active_dir"}, {2'b0, ad_o}, {2'b0, x.act_dir});
  endtask

  // Drive one cycle of lamps/clear, then compare the state after the sampling edge.
  task automatic step(input string tag, input lamps_t l, input logic c, input bit on_b,
                      input logic ea, input logic ef, input logic [2:0] ec, input logic [1:0] ed);
    lamps = l;
    clr   = c;
    expect_out(tag, on_b, ea, ef, ec, ed);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    lamps = lit(0, LAMP_GRN);
    #1 rst_n = 1'b1;
    #1;
    expect_out("reset_a", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    expect_out("reset_b", 1'b1, 1'b0, 1'b0, 3'd0, 2'd0);
    check_front();
    check_front();
    @(negedge clk);
    rst_n = 1'b0;

    // Legal rotation; the first green is sampled on the arming edge, clear in RUN is ignored.
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 4; d++) begin
        step($sformatf("legal_g_r%0d_d%0d", r, d), lit(d, LAMP_GRN), (r == 1 && d == 2),
             1'b0, 1'b1, 1'b0, 3'd0, 2'd0);
        step($sformatf("legal_y_r%0d_d%0d", r, d), lit(d, LAMP_YEL), 1'b0,
             1'b0, 1'b1, 1'b0, 3'd0, 2'd0);
      end
    end

    step("conflict", lit2(0, LAMP_GRN, 1, LAMP_GRN), 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 2'd0);
    for (int i = 0; i < 10; i++) begin
      step($sformatf("conflict_hold%0d", i), (i % 2 == 0) ? lit(-1, LAMP_RED) : lit(2, 3'b011),
           1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 2'd0);
    end

    step("clear1",   lit(0, LAMP_GRN), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    step("rearm1",   lit(0, LAMP_GRN), 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0);
    step("seq_hold", lit(0, LAMP_GRN), 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0);
    step("seq_skip", lit(-1, LAMP_RED), 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 2'd0);

    step("clear2",  lit(-1, LAMP_RED), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    step("rearm2",  lit(-1, LAMP_RED), 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0);
    step("invalid", lit2(0, LAMP_GRN, 2, 3'b011), 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 2'd2);

    step("clear3", lit(3, LAMP_GRN), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    step("rearm3", lit(3, LAMP_GRN), 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      step($sformatf("yel_hold%0d", i), lit(3, LAMP_YEL), 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0);
    end
    step("long_yel", lit(3, LAMP_YEL), 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 2'd3);

    step("clear4", lit(-1, LAMP_RED), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    step("rearm4", lit(-1, LAMP_RED), 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      step($sformatf("all_red%0d", i), lit(-1, LAMP_RED), 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0);
    end
    step("stall", lit(-1, LAMP_RED), 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 2'd0);

    step("clear_conf", lit2(0, LAMP_GRN, 1, LAMP_GRN), 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    step("rearm5",     lit2(0, LAMP_GRN, 1, LAMP_GRN), 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0);
    step("conflict2",  lit2(0, LAMP_GRN, 1, LAMP_GRN), 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 2'd0);

    // Asynchronous reset while latched: outputs drop without a clock edge.
    expect_out("rst_in_fault", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    rst_n = 1'b1;
    #1;
    check_front();
    @(negedge clk);
    lamps = lit(0, LAMP_GRN);
    rst_n = 1'b0;

    // MIN_GREEN=3 instance: a short first green is tolerated, a later one is not.
    step("b_arm",     lit(0, LAMP_GRN), 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
    step("b_first",   lit(0, LAMP_YEL), 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
    step("b_e_green", lit(1, LAMP_GRN), 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
    step("b_e_hold",  lit(1, LAMP_GRN), 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
    step("b_short",   lit(1, LAMP_YEL), 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_monitor.md
# traffic_lamp_monitor

Conflict monitor at the receiving end of the four-approach lamp bus driven by the traffic controller. It samples the north/east/south/west 3-bit lamp codes every clock and checks them for:
- code validity
- conflicting right-of-way
- legal green→yellow→red sequencing
- minimum and maximum dwell times

On the first violation it latches a fault, its code and its direction, and raises a flash-red request to the cabinet safety logic. The fault holds until software clears it.

## Interface
- CNT_W, 8: dwell counter width; counters saturate at 2^CNT_W-1.
- MIN_GREEN, 1: minimum cycles a green must be held.
- MAX_GREEN, 16: maximum cycles a green may be held.
- MIN_YELLOW, 1: minimum cycles a yellow must be held.
- MAX_YELLOW, 4: maximum cycles a yellow may be held.
- MAX_ALL_RED, 4: maximum consecutive cycles with all four approaches red.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- north, east, south, west  in  3 each  lamp codes: 001 red, 010 yellow, 100 green.
- clear  in  1  synchronous fault acknowledge.
- armed  out  1  monitor is checking (RUN state).
- fault  out  1  sticky fault flag.
- flash_red  out  1  flash-red request; equals fault.
- fault_code  out  3  0 NONE, 1 INVALID, 2 CONFLICT, 3 SEQUENCE, 4 SHORT, 5 LONG, 6 STALL.
- fault_dir  out  2  0 N, 1 E, 2 S, 3 W; 0 for CONFLICT and STALL.
- active_dir  out  2  approach currently non-red; 0 when none.
- active_valid  out  1  exactly one approach is non-red.

## Operation
- States: IDLE, RUN, FAULT. Reset enters IDLE with all outputs 0.
- IDLE: capture all four codes as the previous sample and clear the dwell counters. Move to RUN on the next edge. No checks run in IDLE.
- RUN: each edge, evaluate the current inputs against the previous sample and the per-approach dwell counters.
  - INVALID: any code not in {001, 010, 100}.
  - CONFLICT: two or more approaches non-red.
  - SEQUENCE: any transition other than G→Y, Y→R, R→G, or hold.
  - SHORT: G→Y with green dwell < MIN_GREEN, or Y→R with yellow dwell < MIN_YELLOW.
  - LONG: green dwell would exceed MAX_GREEN, or yellow dwell would exceed MAX_YELLOW.
  - STALL: all-red dwell would exceed MAX_ALL_RED.
- Dwell: 1 on the first cycle of a new code, +1 per held cycle, saturating. The all-red counter counts consecutive all-red cycles.
- First phase after arming: SHORT checks are suppressed for each approach until that approach has completed one full code change. The starting dwell of that phase is unknown.
- Simultaneous violations: report the lowest fault_code number. Within one code, report the lowest direction index.
- On a fault: latch fault_code and fault_dir, set fault and flash_red, enter FAULT. Tracking freezes.
- FAULT: outputs hold. clear returns to IDLE on the next edge, and fault, flash_red, fault_code and fault_dir go to 0 at that same edge. clear in IDLE or RUN is ignored.
- active_dir and active_valid are combinational from the current inputs in every state.
- rst_n mid-operation: immediate return to IDLE with all outputs 0, including a latched fault.

## Timing
- Detection is combinational on the inputs against registered state. fault and fault_code rise at the edge that samples the offending inputs (1-edge latency).
- Arming latency: armed = 1 one edge after reset release or clear.
- The controller updates its lamps at clock edges. The monitor sees each new code one edge after the controller changes it.
- clear asserted in the same cycle a new violation appears while in FAULT: clear wins (IDLE, no re-latch).

## Structure
- Shared package traffic_pkg holds:
  - lamp constants LAMP_RED/YEL/GRN
  - direction enum DIR_N/E/S/W
  - fault code enum
  - monitor state enum
- Sub-module traffic_lamp_tracker, instantiated 4x, one per approach. It holds the previous code, the dwell counter and the first-phase flag. It outputs invalid, seq_err, short_err, long_err and non_red.
- The top level holds the FSM, the conflict and all-red logic, and the priority encoder.

## Test plan
- Legal cycle: N G1 Y1 → E G1 Y1 → S → W, repeated 3 rounds → fault stays 0, armed = 1, active_dir steps 0,1,2,3.
- Conflict: north = 100 and east = 100 in one cycle → fault_code = 2, fault_dir = 0, flash_red = 1 at the next edge, outputs held for 10 cycles.
- Skipped yellow: N green → N red → fault_code = 3, fault_dir = 0. Invalid code south = 011 → fault_code = 1, fault_dir = 2.
- Dwell limits with MIN_GREEN = 3: E green 2 cycles then yellow → fault_code = 4, fault_dir = 1. With default MAX_YELLOW, W yellow 5 cycles → fault_code = 5, fault_dir = 3.
- All red for 5 cycles → fault_code = 6. Then clear together with a conflicting input → IDLE, fault = 0, re-armed next edge.
- rst_n pulse while in FAULT → all outputs 0 immediately. First phase after arming: green 1 cycle with MIN_GREEN = 3 → no SHORT fault.
